// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM encodings and the
// per-cycle pipeline control bundle with its canned values.
package hz_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE   = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pipe_freeze: 1'b1, default: 1'b0};

  // Resolution of a non-waiting cycle: branch flush outranks load-use stall.
  function automatic hz_ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
    hz_ctrl_t c;
    c = CTRL_IDLE;
    if (branch_taken) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_write    = 1'b0;
      c.ifid_write  = 1'b0;
      c.idex_bubble = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signal bundle of the hazard control unit.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       IFID_rs1;
  logic [4:0]       IFID_rs2;
  logic [4:0]       IDEX_rd;
  logic             IDEX_MemRead;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             Pipe_Freeze;
  logic             mem_timeout;
  logic [1:0]       hz_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead, branch_taken, mem_req, mem_ready,
    input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze,
           mem_timeout, hz_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  IFID_rs1, IFID_rs2, IDEX_rd, IDEX_MemRead, branch_taken, mem_req, mem_ready,
    output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze,
           mem_timeout, hz_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// with timeout, plus saturating stall/flush performance counters.
module hazard_control_unit
  import hz_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_control_unit_if.slave hz
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  hz_state_e         state;
  hz_state_e         state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_wait;
  logic              timeout_flag;
  hz_ctrl_t          ctrl;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  assign load_use = hz.IDEX_MemRead && (hz.IDEX_rd != 5'd0) &&
                    ((hz.IDEX_rd == hz.IFID_rs1) || (hz.IDEX_rd == hz.IFID_rs2));
  assign mem_wait = hz.mem_req && !hz.mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == MEM_WAIT) && (state_next == MEM_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Outputs are decoded from the current inputs so stall/flush/freeze act in
  // the same cycle the hazard appears; reset forces the idle pattern.
  always_comb begin
    state_next   = state;
    ctrl         = CTRL_IDLE;
    timeout_flag = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          ctrl       = CTRL_FREEZE;
          state_next = MEM_WAIT;
        end else begin
          ctrl = run_ctrl(hz.branch_taken, load_use);
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          ctrl       = run_ctrl(hz.branch_taken, load_use);
          state_next = RUN;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == WAIT_LAST) begin
            state_next = ERROR;
          end
        end
      end
      ERROR: begin
        ctrl         = CTRL_FREEZE;
        timeout_flag = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (!rst_n) begin
      ctrl         = CTRL_IDLE;
      timeout_flag = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctrl.pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.ifid_flush),
    .count (flush_count)
  );

  assign hz.PC_Write    = ctrl.pc_write;
  assign hz.IFID_Write  = ctrl.ifid_write;
  assign hz.IDEX_Bubble = ctrl.idex_bubble;
  assign hz.IFID_Flush  = ctrl.ifid_flush;
  assign hz.IDEX_Flush  = ctrl.idex_flush;
  assign hz.Pipe_Freeze = ctrl.pipe_freeze;
  assign hz.mem_timeout = timeout_flag;
  assign hz.hz_state    = rst_n ? state : RUN;
  assign hz.stall_cnt   = stall_count;
  assign hz.flush_cnt   = flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (TIMEOUT_CYCLES=8, CNT_W=4).
module tb_hazard_control_unit;

  localparam int unsigned TOUT = 8;
  localparam int unsigned CW   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_control_unit_if #(.CNT_W(CW)) hz ();

  hazard_control_unit #(.TIMEOUT_CYCLES(TOUT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // exp bits: {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze}
  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       branch;
    logic       mreq;
    logic       mrdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctrl_now();
    return {26'd0, hz.PC_Write, hz.IFID_Write, hz.IDEX_Bubble,
            hz.IFID_Flush, hz.IDEX_Flush, hz.Pipe_Freeze};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic memread, input logic branch, input logic mreq,
                       input logic mrdy);
    hz.IFID_rs1     = rs1;
    hz.IFID_rs2     = rs2;
    hz.IDEX_rd      = rd;
    hz.IDEX_MemRead = memread;
    hz.branch_taken = branch;
    hz.mem_req      = mreq;
    hz.mem_ready    = mrdy;
  endtask

  task automatic idle_in();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    idle_in();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"idle",          5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000};
    vecs[1] = '{"lu_rs1",        5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001000};
    vecs[2] = '{"lu_rs2",        5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b001000};
    vecs[3] = '{"rd_x0",         5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110000};
    vecs[4] = '{"no_memread",    5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000};
    vecs[5] = '{"rd_mismatch",   5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110000};
    vecs[6] = '{"branch",        5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b110110};
    vecs[7] = '{"branch_over_lu",5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'b110110};
    vecs[8] = '{"mem_ready_lu",  5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 6'b001000};
    vecs[9] = '{"mem_ready_idle",5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110000};

    // Outputs held idle while in reset, even with hazards present.
    rst_n = 1'b0;
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_ctrl", ctrl_now(), 32'h30);
    chk("rst_timeout", 32'(hz.mem_timeout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    idle_in();
    #1;
    chk("rst_state", 32'(hz.hz_state), 32'd0);
    chk("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // Single-cycle RUN decoding.
    foreach (vecs[i]) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].memread,
            vecs[i].branch, vecs[i].mreq, vecs[i].mrdy);
      #1;
      chk({vecs[i].name, "_ctrl"}, ctrl_now(), 32'(vecs[i].exp));
      tick();
      chk({vecs[i].name, "_state"}, 32'(hz.hz_state), 32'd0);
    end

    // Load-use stalls exactly one cycle.
    reset_pulse();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stall", ctrl_now(), 32'h08);
    tick();
    idle_in();
    #1;
    chk("lu_release", ctrl_now(), 32'h30);
    tick();
    chk("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
    chk("lu_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // Branch wins over coincident load-use.
    reset_pulse();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("br_lu_ctrl", ctrl_now(), 32'h36);
    tick();
    idle_in();
    tick();
    chk("br_flush_cnt", 32'(hz.flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(hz.stall_cnt), 32'd0);

    // Four-cycle memory wait, released together with a taken branch.
    reset_pulse();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_freeze", ctrl_now(), 32'h01);
      chk("mw_state", 32'(hz.hz_state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("mw_release_ctrl", ctrl_now(), 32'h36);
    chk("mw_release_state", 32'(hz.hz_state), 32'd1);
    tick();
    idle_in();
    chk("mw_after_state", 32'(hz.hz_state), 32'd0);
    chk("mw_stall_cnt", 32'(hz.stall_cnt), 32'd4);
    chk("mw_flush_cnt", 32'(hz.flush_cnt), 32'd1);

    // Reset in the middle of a wait returns to RUN regardless of mem_ready.
    reset_pulse();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("mid_wait_state", 32'(hz.hz_state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_wait_rst_ctrl", ctrl_now(), 32'h30);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_wait_after_rst", 32'(hz.hz_state), 32'd0);
    chk("mid_wait_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    idle_in();

    // Timeout after eight MEM_WAIT cycles; ERROR ignores mem_ready.
    reset_pulse();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < int'(TOUT); i++) begin
      chk("to_wait_state", 32'(hz.hz_state), 32'd1);
      tick();
    end
    chk("to_err_state", 32'(hz.hz_state), 32'd2);
    chk("to_err_flag", 32'(hz.mem_timeout), 32'd1);
    chk("to_err_ctrl", ctrl_now(), 32'h01);
    hz.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("to_err_sticky_state", 32'(hz.hz_state), 32'd2);
    chk("to_err_sticky_flag", 32'(hz.mem_timeout), 32'd1);
    chk("to_stall_cnt", 32'(hz.stall_cnt), 32'd12);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_in();
    #1;
    chk("to_rst_state", 32'(hz.hz_state), 32'd0);
    chk("to_rst_flag", 32'(hz.mem_timeout), 32'd0);
    chk("to_rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("to_rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);

    // Counter saturation at all-ones.
    reset_pulse();
    drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("sat_stall_cnt", 32'(hz.stall_cnt), 32'd15);
    tick();
    chk("sat_stall_hold", 32'(hz.stall_cnt), 32'd15);
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: MEM_WAIT cycles before the timeout error.
REQ-002 SHALL have parameter CNT_W, default 16: width of each performance counter.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 IFID_rs1, IFID_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 IDEX_rd  in  5  destination of the instruction in EX; IDEX_MemRead  in  1  that instruction is a load.
REQ-007 branch_taken  in  1  EX resolved a taken branch or jump.
REQ-008 mem_req  in  1  MEM stage has an active data-memory access; mem_ready  in  1  memory completes the access this cycle.
REQ-009 PC_Write, IFID_Write  out  1 each  enable PC and IF/ID updates.
REQ-010 IDEX_Bubble  out  1  zero ID/EX control signals (insert a NOP).
REQ-011 IFID_Flush, IDEX_Flush  out  1 each  squash the instruction in that register.
REQ-012 Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-013 mem_timeout  out  1  sticky error flag.
REQ-014 hz_state  out  2  current FSM state.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-016 The FSM SHALL have three states: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10.
REQ-017 Control outputs SHALL be combinational from the state and current inputs, giving zero-latency stall, flush and freeze.
REQ-018 Load-use SHALL be detected when IDEX_MemRead=1, IDEX_rd!=0, and IDEX_rd equals IFID_rs1 or IFID_rs2.
REQ-019 In RUN with no event, PC_Write=IFID_Write=1 and all other control outputs SHALL be 0.
REQ-020 Priority in RUN SHALL be: memory wait, then branch flush, then load-use.
REQ-021 Memory wait (mem_req=1, mem_ready=0) in RUN:
- PC_Write=IFID_Write=0 and Pipe_Freeze=1 in the same cycle;
- next state SHALL be MEM_WAIT.
REQ-022 Taken branch in RUN with no memory wait:
- IFID_Flush=IDEX_Flush=1 and PC_Write=1, so the PC loads the target;
- a coincident load-use SHALL be ignored;
- the state SHALL stay RUN.
REQ-023 Load-use in RUN with no higher-priority event: PC_Write=IFID_Write=0 and IDEX_Bubble=1 for exactly one cycle (MEM/WB forwarding covers the rest); the state SHALL stay RUN.
REQ-024 In MEM_WAIT, the freeze outputs of REQ-021 SHALL hold every cycle mem_ready=0.
REQ-025 When mem_ready=1 in MEM_WAIT:
- the freeze SHALL release that cycle and the state SHALL return to RUN;
- branch_taken and load-use SHALL be evaluated in that same cycle as in RUN.
REQ-026 A wait counter SHALL count MEM_WAIT cycles.
- On entering RUN it SHALL clear.
- On reaching TIMEOUT_CYCLES with mem_ready still 0, the next state SHALL be ERROR.
REQ-027 In ERROR:
- Pipe_Freeze=1, PC_Write=IFID_Write=0 and mem_timeout=1;
- ERROR SHALL be left only by reset.
REQ-028 stall_cnt SHALL increment by 1 on every cycle with PC_Write=0 (load-use, MEM_WAIT or ERROR).
REQ-029 flush_cnt SHALL increment by 1 per cycle with IFID_Flush=1.
REQ-030 Both counters SHALL saturate at all-ones with no wrap-around.

Reset
REQ-031 When rst_n=0 at a clock edge:
- the state SHALL be RUN;
- the wait counter, stall_cnt, flush_cnt and mem_timeout SHALL be 0.
REQ-032 Reset mid-MEM_WAIT or in ERROR SHALL return to RUN in the next cycle, independent of mem_ready.
REQ-033 While rst_n=0, outputs SHALL be the RUN idle values: PC_Write=IFID_Write=1, all others 0.

Structure
REQ-034 The state encodings and the RUN-idle output defaults SHALL live in the shared package hz_pkg.
REQ-035 One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count), SHALL be instantiated twice for stall_cnt and flush_cnt.
REQ-036 The load-use compare SHALL stay inline in hazard_control_unit.

Verification
REQ-037 Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5 for one cycle -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly 1 cycle; stall_cnt=1.
REQ-038 rd=x0: IDEX_MemRead=1, IDEX_rd=0, IFID_rs1=0 -> no stall; PC_Write=1.
REQ-039 Branch beats load-use: branch_taken=1 together with the REQ-037 load-use -> IFID_Flush=IDEX_Flush=1, IDEX_Bubble=0; flush_cnt=1, stall_cnt=0.
REQ-040 Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> Pipe_Freeze=1 for 4 cycles; hz_state=01 during the wait and 00 after; stall_cnt=4.
REQ-041 Timeout: TIMEOUT_CYCLES=8, mem_ready held 0 -> hz_state=10 and mem_timeout=1 after 8 wait cycles; mem_ready=1 has no effect; rst_n=0 for one cycle -> RUN, all counters 0.
REQ-042 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15 and holds at 15.
